rx_capture_sched: RTL and testbench

Sequencer and port arbiter for the receiver's PL-side BRAM port, shared between raw sample capture and the PS mailbox flag. On `en` it writes one frame of N_SAMPLES words into the buffer region, then raises the ready flag at FLAG_ADDR. It polls that flag until the PS clears it, then pulses `rst_count` to restart the upstream sample counter. It sits between the ADC/decimation sample stream and the BRAM controller IP, replacing ad-hoc single-purpose flag logic.

---
 rtl/rx_capture_sched.sv | 163 ++++++++++++++++
 tb/tb_rx_capture_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_capture_sched.sv
// ---------------------------------------------------------------------------
// rx_capture_sched
// Sequences one capture frame into the shared PL-side BRAM port, then raises
// the PS mailbox flag and waits for the PS to clear it before restarting the
// upstream sample counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | port quiet, waiting for en
// CAPTURE | each valid sample is written to BUF_BASE + index
// FLAG_WR | flag word (1) held on FLAG_ADDR for HOLD_CYCLES cycles
// POLL    | reading FLAG_ADDR; dout trusted after RD_LAT cycles
// ACK     | PS cleared the flag; rst_count pulse, frame counted
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   en                frame request, sampled only in IDLE
//   sample_valid/data sample stream, no backpressure
//   dout              BRAM read data, bit 0 is the handshake flag
//   valid, din, addr  BRAM write enable / data / word address
//   rst_count         one-cycle pulse once the PS acknowledges
//   busy              high outside IDLE
//   frame_cnt         completed frames (wrapping)
//   overrun_cnt       samples dropped after capture (saturating)
// ---------------------------------------------------------------------------
module rx_capture_sched #(
    parameter int N_SAMPLES   = 1024,
    parameter int BUF_BASE    = 0,
    parameter int FLAG_ADDR   = 2047,
    parameter int HOLD_CYCLES = 3,
    parameter int RD_LAT      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        sample_valid,
    input  logic [31:0] sample_data,
    input  logic [31:0] dout,
    output logic        valid,
    output logic [31:0] din,
    output logic [31:0] addr,
    output logic        rst_count,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] overrun_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        FLAG_WR = 3'd2,
        POLL    = 3'd3,
        ACK     = 3'd4
    } state_t;

    localparam logic [31:0] LAST_IDX  = 32'(N_SAMPLES - 1);
    localparam logic [31:0] BASE_ADDR = 32'(BUF_BASE);
    localparam logic [31:0] FLAG_WORD = 32'(FLAG_ADDR);
    localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES);
    // One extra count because the first POLL state cycle is still showing
    // the last flag write on the port (outputs are registered).
    localparam logic [31:0] POLL_LOAD = 32'(RD_LAT + 1);

    state_t      state;
    logic [31:0] idx;
    logic [31:0] hold_cnt;
    logic [31:0] poll_cnt;
    logic        dropped;
    logic        unused_dout;

    assign unused_dout = ^dout[31:1];

    // Samples arriving after the capture phase are lost; IDLE samples are not.
    assign dropped = sample_valid &&
                     ((state == FLAG_WR) || (state == POLL) || (state == ACK));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            hold_cnt    <= '0;
            poll_cnt    <= '0;
            valid       <= 1'b0;
            din         <= '0;
            addr        <= '0;
            rst_count   <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
        end else begin
            rst_count <= 1'b0;
            if (dropped && (overrun_cnt != 16'hFFFF)) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    addr  <= '0;
                    din   <= '0;
                    if (en) begin
                        state <= CAPTURE;
                        busy  <= 1'b1;
                        idx   <= '0;
                    end
                end

                CAPTURE: begin
                    valid <= sample_valid;
                    if (sample_valid) begin
                        addr <= BASE_ADDR + idx;
                        din  <= sample_data;
                        idx  <= idx + 32'd1;
                        if (idx == LAST_IDX) begin
                            state    <= FLAG_WR;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end
                end

                FLAG_WR: begin
                    valid <= 1'b1;
                    addr  <= FLAG_WORD;
                    din   <= 32'h1;
                    if (hold_cnt == 32'd1) begin
                        state    <= POLL;
                        poll_cnt <= POLL_LOAD;
                    end else begin
                        hold_cnt <= hold_cnt - 32'd1;
                    end
                end

                POLL: begin
                    valid <= 1'b0;
                    addr  <= FLAG_WORD;
                    din   <= '0;
                    if (poll_cnt != 32'd0) begin
                        poll_cnt <= poll_cnt - 32'd1;
                    end else if (!dout[0]) begin
                        state     <= ACK;
                        rst_count <= 1'b1;
                    end
                end

                ACK: begin
                    valid     <= 1'b0;
                    addr      <= '0;
                    din       <= '0;
                    busy      <= 1'b0;
                    frame_cnt <= frame_cnt + 16'd1;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_capture_sched.sv
// ---------------------------------------------------------------------------
// tb_rx_capture_sched
// Table-driven basic frame, hand sequences for reset / gaps / long poll /
// overrun / back-to-back, then random stimulus against a time-based model.
// ---------------------------------------------------------------------------
module tb_rx_capture_sched;

    localparam int N  = 8;
    localparam int BB = 0;
    localparam int FA = 2047;
    localparam int H  = 3;
    localparam int RL = 2;

    logic        clk;
    logic        rst;
    logic        en;
    logic        sample_valid;
    logic [31:0] sample_data;
    logic [31:0] dout;
    logic        valid;
    logic [31:0] din;
    logic [31:0] addr;
    logic        rst_count;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [15:0] overrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    rx_capture_sched #(
        .N_SAMPLES  (N),
        .BUF_BASE   (BB),
        .FLAG_ADDR  (FA),
        .HOLD_CYCLES(H),
        .RD_LAT     (RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sample_valid(sample_valid),
        .sample_data(sample_data),
        .dout       (dout),
        .valid      (valid),
        .din        (din),
        .addr       (addr),
        .rst_count  (rst_count),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .overrun_cnt(overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (event times, not states) -----------
    // phase 0: idle, 1: capturing, 2: after last sample (flag/poll/ack)
    bit          m_ok = 1'b0;
    int          mph = 0;
    int          mk = 0;
    longint      cyc = 0;
    longint      tl = 0;
    longint      tp = 0;
    bit          p_found = 1'b0;
    logic        e_v, e_b, e_rc;
    logic [31:0] e_a, e_d;
    bit          e_a_k, e_d_k;
    logic [15:0] e_fc, e_ov;

    task automatic model_step();
        longint x;
        if (m_ok) begin
            chk("valid", {31'd0, valid}, {31'd0, e_v});
            if (e_a_k) chk("addr", addr, e_a);
            if (e_d_k) chk("din", din, e_d);
            chk("busy", {31'd0, busy}, {31'd0, e_b});
            chk("rst_count", {31'd0, rst_count}, {31'd0, e_rc});
            chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, e_fc});
            chk("overrun_cnt", {16'd0, overrun_cnt}, {16'd0, e_ov});
        end
        x = cyc + 1;
        if (rst) begin
            m_ok = 1'b1; mph = 0; mk = 0; p_found = 1'b0;
            e_v = 1'b0; e_a = '0; e_d = '0; e_a_k = 1'b1; e_d_k = 1'b1;
            e_b = 1'b0; e_rc = 1'b0; e_fc = '0; e_ov = '0;
        end else if (m_ok) begin
            e_rc = 1'b0; e_a_k = 1'b0; e_d_k = 1'b0;
            if (mph == 0) begin
                e_v = 1'b0; e_a = '0; e_a_k = 1'b1;
                e_b = en;
                if (en) begin mph = 1; mk = 0; end
            end else if (mph == 1) begin
                e_b = 1'b1;
                e_v = sample_valid;
                if (sample_valid) begin
                    e_a = 32'(BB + mk); e_d = sample_data; e_a_k = 1'b1; e_d_k = 1'b1;
                    mk++;
                    if (mk == N) begin tl = cyc; mph = 2; p_found = 1'b0; end
                end
            end else begin
                if (sample_valid && e_ov != 16'hFFFF) e_ov = e_ov + 16'd1;
                if (!p_found && cyc >= tl + 2 + H + RL && dout[0] == 1'b0) begin
                    p_found = 1'b1; tp = cyc;
                end
                if (x <= tl + 1 + H) begin
                    e_v = 1'b1; e_a = FA; e_d = 32'h1; e_a_k = 1'b1; e_d_k = 1'b1; e_b = 1'b1;
                end else if (!p_found || x <= tp + 1) begin
                    e_v = 1'b0; e_a = FA; e_d = '0; e_a_k = 1'b1; e_d_k = 1'b1; e_b = 1'b1;
                    e_rc = (p_found && x == tp + 1);
                end else begin
                    e_v = 1'b0; e_a = '0; e_a_k = 1'b1; e_b = 1'b0;
                    e_fc = e_fc + 16'd1;
                    mph = 0;
                end
            end
        end
        cyc++;
    endtask

    // One clock cycle of stimulus; returns just after the closing edge.
    task automatic step(input logic r, input logic e, input logic s,
                        input logic [31:0] sd, input logic [31:0] dv);
        rst = r; en = e; sample_valid = s; sample_data = sd; dout = dv;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------------------------------
    typedef struct {
        logic        r, e, s;
        logic [31:0] sd, dv;
        logic        ev;
        logic [31:0] ea, ed;
        bit          cd;
        logic        eb, erc;
        logic [15:0] efc, eov;
    } vec_t;

    vec_t tbl [20];

    task automatic set_row(input int i, input logic r, input logic e, input logic s,
                           input logic [31:0] sd, input logic [31:0] dv,
                           input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                           input bit cd, input logic eb, input logic erc,
                           input logic [15:0] efc, input logic [15:0] eov);
        tbl[i].r = r; tbl[i].e = e; tbl[i].s = s; tbl[i].sd = sd; tbl[i].dv = dv;
        tbl[i].ev = ev; tbl[i].ea = ea; tbl[i].ed = ed; tbl[i].cd = cd;
        tbl[i].eb = eb; tbl[i].erc = erc; tbl[i].efc = efc; tbl[i].eov = eov;
    endtask

    initial begin
        int writes, rc_seen, idle_seen, bad;
        bit done;
        logic [31:0] dv;

        // basic frame: reset, request, 8 samples, flag, poll, ack, idle
        set_row(0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 0);
        set_row(1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < N; i++)
            set_row(2 + i, 0, 0, 1, 32'hA0 + i, 0, 1, BB + i, 32'hA0 + i, 1, 1, 0, 0, 0);
        set_row(10, 0, 0, 0, 0, 1,     1, FA, 1, 1, 1, 0, 0, 0);
        set_row(11, 0, 0, 1, 32'hFF, 1, 1, FA, 1, 1, 1, 0, 0, 1);
        set_row(12, 0, 0, 0, 0, 1,     1, FA, 1, 1, 1, 0, 0, 1);
        set_row(13, 0, 0, 0, 0, 0,     0, FA, 0, 1, 1, 0, 0, 1);
        set_row(14, 0, 0, 0, 0, 0,     0, FA, 0, 1, 1, 0, 0, 1);
        set_row(15, 0, 0, 0, 0, 0,     0, FA, 0, 1, 1, 0, 0, 1);
        set_row(16, 0, 0, 0, 0, 1,     0, FA, 0, 1, 1, 0, 0, 1);
        set_row(17, 0, 0, 0, 0, 0,     0, FA, 0, 1, 1, 1, 0, 1);
        set_row(18, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 1, 1);
        set_row(19, 0, 0, 1, 32'h55, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        rst = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_data = '0; dout = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].sd, tbl[i].dv);
            chk($sformatf("tbl%0d.valid", i), {31'd0, valid}, {31'd0, tbl[i].ev});
            chk($sformatf("tbl%0d.addr", i), addr, tbl[i].ea);
            if (tbl[i].cd) chk($sformatf("tbl%0d.din", i), din, tbl[i].ed);
            chk($sformatf("tbl%0d.busy", i), {31'd0, busy}, {31'd0, tbl[i].eb});
            chk($sformatf("tbl%0d.rst_count", i), {31'd0, rst_count}, {31'd0, tbl[i].erc});
            chk($sformatf("tbl%0d.frame_cnt", i), {16'd0, frame_cnt}, {16'd0, tbl[i].efc});
            chk($sformatf("tbl%0d.overrun", i), {16'd0, overrun_cnt}, {16'd0, tbl[i].eov});
        end

        // reset mid-capture at index 5
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'hB0 + i, 1);
        step(1, 1, 1, 32'hB5, 1);
        chk("rst_mid.valid", {31'd0, valid}, 32'd0);
        chk("rst_mid.addr", addr, 32'd0);
        chk("rst_mid.busy", {31'd0, busy}, 32'd0);
        step(1, 1, 1, 32'hB6, 1);
        writes = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 1, 32'hC0 + i, 1);
            if (valid) writes++;
        end
        chk("rst_mid.no_writes_after", writes, 0);
        chk("rst_mid.frame_cnt", {16'd0, frame_cnt}, 32'd0);

        // gapped samples, one every third cycle
        step(0, 1, 0, 0, 1);
        writes = 0;
        for (int i = 0; i < 3 * N; i++) begin
            step(0, 0, (i % 3) == 0, 32'hD0 + i, 1);
            if (valid && addr < FA) begin
                chk("gap.addr_contig", addr, 32'(BB + writes));
                writes++;
            end
        end
        chk("gap.write_count", writes, N);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
        chk("gap.frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // flag still set for 50 poll cycles
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < N; i++) step(0, 0, 1, 32'hE0 + i, 1);
        bad = 0;
        for (int i = 0; i < 1 + H + 50; i++) begin
            step(0, 0, 0, 0, 1);
            if (rst_count || !busy) bad++;
        end
        chk("long_poll.held", bad, 0);
        rc_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0);
            if (rst_count) rc_seen++;
        end
        chk("long_poll.rc_pulses", rc_seen, 1);

        // overrun: samples held through FLAG_WR and 20 POLL cycles
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < N; i++) step(0, 0, 1, 32'hF0 + i, 1);
        writes = 0;
        for (int i = 0; i < H + 20; i++) begin
            step(0, 0, 1, 32'h100 + i, 1);
            if (valid && addr < FA) writes++;
        end
        chk("overrun.no_buf_write", writes, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
        chk("overrun.count", {16'd0, overrun_cnt}, 32'd23);

        // back-to-back: en held for exactly three frames
        step(1, 0, 0, 0, 0);
        rc_seen = 0; idle_seen = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            step(0, 1, 1, 32'h200 + i, 0);
            if (rst_count) rc_seen++;
            if (!busy) idle_seen++;
            if (rc_seen == 3) done = 1'b1;
        end
        chk("b2b.completed", {31'd0, done}, 32'd1);
        chk("b2b.idle_between", idle_seen, 2);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 32'h300 + i, 0);
            if (rst_count) rc_seen++;
        end
        chk("b2b.rc_pulses", rc_seen, 3);
        chk("b2b.frame_cnt", {16'd0, frame_cnt}, 32'd3);

        // random stimulus
        for (int i = 0; i < 3000; i++) begin
            dv = $urandom;
            dv[0] = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), $urandom, dv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
